// File: rtl/mlp_pass_sequencer.sv
// Pass sequencer for the int8 MLP accelerator: loads ifmap/weight/bias words into
// the GLB, kicks the PE array, then drains the output buffer; two passes per job.
module mlp_pass_sequencer #(
    parameter int IFMAP_WORDS  = 16,
    parameter int WEIGHT_WORDS = 1024,
    parameter int BIAS_WORDS   = 64,
    parameter int OUT_WORDS    = 64,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              ready,
    input  logic              i_en,
    input  logic [31:0]       data_in,
    output logic              glb_we,
    output logic [1:0]        glb_sel,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [31:0]       glb_wdata,
    output logic              pe_start,
    input  logic              pe_done,
    output logic              ob_rd_en,
    output logic [ADDR_W-1:0] ob_addr,
    input  logic [31:0]       ob_rdata,
    output logic              valid,
    output logic [31:0]       ofmap,
    output logic              mode_q,
    output logic              pass_id,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(WEIGHT_WORDS);

    typedef enum logic [2:0] {
        IDLE, LD_IF, LD_W, LD_B, COMPUTE, DRAIN, PASS_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              glb_we_q, glb_we_d;
    logic [1:0]        glb_sel_q, glb_sel_d;
    logic [ADDR_W-1:0] glb_addr_q, glb_addr_d;
    logic [31:0]       glb_wdata_q, glb_wdata_d;
    logic              pe_start_q, pe_start_d;
    logic              ob_rd_en_q, ob_rd_en_d;
    logic [ADDR_W-1:0] ob_addr_q, ob_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              valid_q, valid_d;
    logic [31:0]       ofmap_q, ofmap_d;
    logic              mode_lat_q, mode_lat_d;
    logic              pass_id_q, pass_id_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        region_sel;
    logic [CNT_W-1:0]  region_last;

    always_comb begin
        region_sel  = 2'd0;
        region_last = '0;
        case (state_q)
            LD_IF: begin region_sel = 2'd0; region_last = CNT_W'(IFMAP_WORDS - 1);  end
            LD_W:  begin region_sel = 2'd1; region_last = CNT_W'(WEIGHT_WORDS - 1); end
            LD_B:  begin region_sel = 2'd2; region_last = CNT_W'(BIAS_WORDS - 1);   end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        glb_we_d    = 1'b0;
        glb_sel_d   = glb_sel_q;
        glb_addr_d  = glb_addr_q;
        glb_wdata_d = glb_wdata_q;
        pe_start_d  = 1'b0;
        ob_rd_en_d  = 1'b0;
        ob_addr_d   = '0;
        // Read data arrives one cycle after the read strobe; register it once more.
        rd_pend_d   = ob_rd_en_q;
        valid_d     = rd_pend_q;
        ofmap_d     = rd_pend_q ? ob_rdata : ofmap_q;
        mode_lat_d  = mode_lat_q;
        pass_id_d   = pass_id_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d    = LD_IF;
                    mode_lat_d = mode;
                    pass_id_d  = 1'b0;
                    cnt_d      = '0;
                end
            end
            LD_IF, LD_W, LD_B: begin
                if (i_en) begin
                    glb_we_d    = 1'b1;
                    glb_sel_d   = region_sel;
                    glb_addr_d  = ADDR_W'(cnt_q);
                    glb_wdata_d = data_in;
                    if (cnt_q == region_last) begin
                        cnt_d = '0;
                        case (state_q)
                            LD_IF:   state_d = LD_W;
                            LD_W:    state_d = LD_B;
                            default: begin
                                state_d    = COMPUTE;
                                pe_start_d = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (pe_done) begin
                    state_d    = DRAIN;
                    ob_rd_en_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            DRAIN: begin
                if (ob_rd_en_q && ob_addr_q != ADDR_W'(OUT_WORDS - 1)) begin
                    ob_rd_en_d = 1'b1;
                    ob_addr_d  = ob_addr_q + ADDR_W'(1);
                end
                // cnt tracks words already presented on ofmap.
                if (valid_q) begin
                    if (cnt_q == CNT_W'(OUT_WORDS - 1)) begin
                        cnt_d = '0;
                        if (pass_id_q) begin
                            state_d   = IDLE;
                            pass_id_d = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = PASS_WAIT;
                            pass_id_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PASS_WAIT: begin
                if (ready) begin
                    state_d = LD_IF;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            glb_we_q    <= 1'b0;
            glb_sel_q   <= 2'd0;
            glb_addr_q  <= '0;
            glb_wdata_q <= '0;
            pe_start_q  <= 1'b0;
            ob_rd_en_q  <= 1'b0;
            ob_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            valid_q     <= 1'b0;
            ofmap_q     <= '0;
            mode_lat_q  <= 1'b0;
            pass_id_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            glb_we_q    <= glb_we_d;
            glb_sel_q   <= glb_sel_d;
            glb_addr_q  <= glb_addr_d;
            glb_wdata_q <= glb_wdata_d;
            pe_start_q  <= pe_start_d;
            ob_rd_en_q  <= ob_rd_en_d;
            ob_addr_q   <= ob_addr_d;
            rd_pend_q   <= rd_pend_d;
            valid_q     <= valid_d;
            ofmap_q     <= ofmap_d;
            mode_lat_q  <= mode_lat_d;
            pass_id_q   <= pass_id_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign glb_we    = glb_we_q;
    assign glb_sel   = glb_sel_q;
    assign glb_addr  = glb_addr_q;
    assign glb_wdata = glb_wdata_q;
    assign pe_start  = pe_start_q;
    assign ob_rd_en  = ob_rd_en_q;
    assign ob_addr   = ob_addr_q;
    assign valid     = valid_q;
    assign ofmap     = ofmap_q;
    assign mode_q    = mode_lat_q;
    assign pass_id   = pass_id_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_mlp_pass_sequencer.sv
// Randomized bench for mlp_pass_sequencer; expectations come from the job word
// index (region ranges) and fixed drain timing arithmetic.
module tb_mlp_pass_sequencer;
    localparam int AW  = 10;
    localparam int IW  = 16;
    localparam int WW  = 1024;
    localparam int BW  = 64;
    localparam int OW  = 64;
    localparam int TOT = IW + WW + BW;

    logic          clk = 1'b0;
    logic          rst, mode, ready, i_en, pe_done;
    logic [31:0]   data_in, ob_rdata;
    logic          glb_we, pe_start, ob_rd_en, valid, mode_q, pass_id, busy, done;
    logic [1:0]    glb_sel;
    logic [AW-1:0] glb_addr, ob_addr;
    logic [31:0]   glb_wdata, ofmap;

    int ntot  = 0;
    int npass = 0;

    mlp_pass_sequencer dut (
        .clk(clk), .rst(rst), .mode(mode), .ready(ready), .i_en(i_en),
        .data_in(data_in), .glb_we(glb_we), .glb_sel(glb_sel),
        .glb_addr(glb_addr), .glb_wdata(glb_wdata), .pe_start(pe_start),
        .pe_done(pe_done), .ob_rd_en(ob_rd_en), .ob_addr(ob_addr),
        .ob_rdata(ob_rdata), .valid(valid), .ofmap(ofmap), .mode_q(mode_q),
        .pass_id(pass_id), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [93:0] all_outs = {glb_we, glb_sel, glb_addr, glb_wdata, pe_start, ob_rd_en,
                            ob_addr, valid, ofmap, mode_q, pass_id, busy, done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; ready = 1'b0; i_en = 1'b0; pe_done = 1'b0;
        data_in = '0; ob_rdata = '0;
        repeat (3) step();
        ntot++;
        if (all_outs !== '0) $display("FAIL reset_outputs got=%h want=0", all_outs);
        else npass++;
        rst = 1'b0;
        // Idle with stray i_en/pe_done: nothing may move.
        for (int k = 0; k < 6; k++) begin
            i_en = 1'($urandom % 2); data_in = $urandom; pe_done = 1'($urandom % 2);
            step();
            ntot++;
            if (all_outs !== '0) $display("FAIL idle_quiet cyc=%0d got=%h want=0", k, all_outs);
            else npass++;
        end
        i_en = 1'b0; pe_done = 1'b0;
        $display("reset: done, %0d/%0d so far", npass, ntot);
    endtask

    task automatic start_pass(input bit m, input bit exp_pass, input bit exp_mode);
        mode = m; ready = 1'b1;
        step();
        ready = 1'b0;
        ntot++;
        if ({busy, pass_id, mode_q, done, glb_we, pe_start} !== {1'b1, exp_pass, exp_mode, 3'b000})
            $display("FAIL start_status got=%b want=%b", {busy, pass_id, mode_q, done, glb_we, pe_start},
                     {1'b1, exp_pass, exp_mode, 3'b000});
        else npass++;
        $display("start: pass=%0d mode_q=%0d", pass_id, mode_q);
    endtask

    // en_mode: 0 = i_en always 1, 1 = toggle during weight region, 2 = random
    task automatic load_pass(input int en_mode, input bit spur, input bit exp_pass, input bit exp_mode);
        int w = 0;
        int cyc = 0;
        int nstart = 0;
        bit en;
        logic [31:0] d;
        logic [1:0] e_sel;
        logic [AW-1:0] e_addr;
        while (w < TOT && cyc < 5000) begin
            if (en_mode == 1) en = (w >= IW && w < IW + WW) ? (cyc % 2 == 0) : 1'b1;
            else if (en_mode == 2) en = ($urandom % 4 != 0);
            else en = 1'b1;
            d = $urandom;
            i_en = en; data_in = d;
            ready   = (spur && w >= IW && w < IW + WW) ? 1'($urandom % 2) : 1'b0;
            pe_done = (spur && w >= IW + WW) ? 1'($urandom % 2) : 1'b0;
            e_sel  = (w < IW) ? 2'd0 : (w < IW + WW) ? 2'd1 : 2'd2;
            e_addr = (w < IW) ? AW'(w) : (w < IW + WW) ? AW'(w - IW) : AW'(w - IW - WW);
            step();
            cyc++;
            ntot++;
            if (en) begin
                if ({glb_we, glb_sel, glb_addr, glb_wdata} !== {1'b1, e_sel, e_addr, d})
                    $display("FAIL glb_write word=%0d got=%b/%0d/%0d/%h want=1/%0d/%0d/%h",
                             w, glb_we, glb_sel, glb_addr, glb_wdata, e_sel, e_addr, d);
                else npass++;
                w++;
            end else begin
                if (glb_we !== 1'b0) $display("FAIL glb_stall word=%0d got glb_we=%b want=0", w, glb_we);
                else npass++;
            end
            ntot++;
            if (pe_start !== (en && w == TOT))
                $display("FAIL pe_start word=%0d got=%b want=%b", w, pe_start, (en && w == TOT));
            else npass++;
            if (pe_start === 1'b1) nstart++;
            ntot++;
            if ({busy, pass_id, mode_q, done, valid, ob_rd_en} !== {1'b1, exp_pass, exp_mode, 3'b000})
                $display("FAIL load_status word=%0d got=%b want=%b", w,
                         {busy, pass_id, mode_q, done, valid, ob_rd_en}, {1'b1, exp_pass, exp_mode, 3'b000});
            else npass++;
        end
        i_en = 1'b0; ready = 1'b0; pe_done = 1'b0;
        ntot++;
        if (w != TOT || nstart != 1)
            $display("FAIL load_complete got words=%0d starts=%0d want=%0d/1", w, nstart, TOT);
        else npass++;
        $display("load: pass=%0d en_mode=%0d words=%0d cycles=%0d", exp_pass, en_mode, w, cyc);
    endtask

    task automatic compute_drain(input bit exp_pass, input int pe_delay, input int abort_at,
                                 input logic [31:0] base);
        bit prev_en = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        bit exp_v;
        int nvalid = 0;
        for (int k = 0; k < pe_delay; k++) begin
            i_en = 1'($urandom % 2); data_in = $urandom; ready = 1'($urandom % 2);
            step();
            ntot++;
            if ({glb_we, pe_start, ob_rd_en, valid, busy, done} !== 6'b000010)
                $display("FAIL compute_quiet cyc=%0d got=%b want=000010", k,
                         {glb_we, pe_start, ob_rd_en, valid, busy, done});
            else npass++;
        end
        i_en = 1'b0; ready = 1'b0; pe_done = 1'b1;
        step();
        pe_done = 1'b0;
        for (int c = 0; c <= 66; c++) begin
            if (c > 0) step();
            // Output-buffer stub with one cycle of read latency.
            ob_rdata  = prev_en ? base + 32'(prev_addr) : $urandom;
            prev_en   = ob_rd_en;
            prev_addr = ob_addr;
            ntot++;
            if (ob_rd_en !== (c < OW)) $display("FAIL ob_rd_en c=%0d got=%b want=%b", c, ob_rd_en, (c < OW));
            else npass++;
            if (c < OW) begin
                ntot++;
                if (ob_addr !== AW'(c)) $display("FAIL ob_addr c=%0d got=%0d want=%0d", c, ob_addr, c);
                else npass++;
            end
            exp_v = (c >= 2 && c < OW + 2);
            ntot++;
            if (valid !== exp_v) $display("FAIL valid c=%0d got=%b want=%b", c, valid, exp_v);
            else npass++;
            if (exp_v) begin
                nvalid++;
                ntot++;
                if (ofmap !== base + 32'(c - 2))
                    $display("FAIL ofmap word=%0d got=%h want=%h", c - 2, ofmap, base + 32'(c - 2));
                else npass++;
            end
            ntot++;
            if (done !== (c == 66 && exp_pass)) $display("FAIL done c=%0d got=%b want=%b", c, done, (c == 66 && exp_pass));
            else npass++;
            ntot++;
            if (c == 66) begin
                if ({busy, pass_id} !== {!exp_pass, !exp_pass})
                    $display("FAIL end_state got busy/pass=%b%b want=%b%b", busy, pass_id, !exp_pass, !exp_pass);
                else npass++;
            end else begin
                if ({busy, pass_id, glb_we, pe_start} !== {1'b1, exp_pass, 2'b00})
                    $display("FAIL drain_status c=%0d got=%b want=%b", c, {busy, pass_id, glb_we, pe_start},
                             {1'b1, exp_pass, 2'b00});
                else npass++;
            end
            if (abort_at >= 0 && exp_v && (c - 2) == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                ntot++;
                if (all_outs !== '0) $display("FAIL abort_outputs got=%h want=0", all_outs);
                else npass++;
                for (int k = 0; k < 6; k++) begin
                    ob_rdata = $urandom; i_en = 1'($urandom % 2); data_in = $urandom;
                    step();
                    ntot++;
                    if (all_outs !== '0) $display("FAIL abort_idle cyc=%0d got=%h want=0", k, all_outs);
                    else npass++;
                end
                i_en = 1'b0;
                $display("drain: aborted by rst after word %0d", abort_at);
                return;
            end
        end
        step();
        ntot++;
        if ({done, valid, ob_rd_en} !== 3'b000) $display("FAIL after_drain got=%b want=000", {done, valid, ob_rd_en});
        else npass++;
        $display("drain: pass=%0d valid_words=%0d busy=%0d", exp_pass, nvalid, busy);
    endtask

    task automatic test_wait_ignores();
        for (int k = 0; k < 5; k++) begin
            i_en = 1'($urandom % 2); data_in = $urandom; pe_done = 1'($urandom % 2);
            step();
            ntot++;
            if ({glb_we, pe_start, ob_rd_en, busy, pass_id, done} !== 6'b000110)
                $display("FAIL pass_wait cyc=%0d got=%b want=000110", k,
                         {glb_we, pe_start, ob_rd_en, busy, pass_id, done});
            else npass++;
        end
        i_en = 1'b0; pe_done = 1'b0;
        $display("pass_wait: stray inputs ignored check done");
    endtask

    task automatic test_load_full();
        start_pass(1'b0, 1'b0, 1'b0);
        load_pass(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_drain_pass0();
        compute_drain(1'b0, 50, -1, 32'h100);
        test_wait_ignores();
    endtask

    task automatic test_toggle_spurious();
        start_pass(1'b1, 1'b1, 1'b0);
        load_pass(1, 1'b1, 1'b1, 1'b0);
        compute_drain(1'b1, $urandom_range(1, 60), -1, 32'h200);
    endtask

    task automatic test_two_pass_mode1();
        start_pass(1'b1, 1'b0, 1'b1);
        load_pass(2, 1'b0, 1'b0, 1'b1);
        compute_drain(1'b0, $urandom_range(1, 60), -1, $urandom);
        mode = 1'b0;
        repeat (3) step();
        start_pass(1'b0, 1'b1, 1'b1);
        load_pass(2, 1'b1, 1'b1, 1'b1);
        compute_drain(1'b1, $urandom_range(1, 60), -1, $urandom);
        ntot++;
        if (busy !== 1'b0) $display("FAIL busy_after_job got=%b want=0", busy);
        else npass++;
    endtask

    task automatic test_reset_mid_drain();
        start_pass(1'b0, 1'b0, 1'b0);
        load_pass(2, 1'b0, 1'b0, 1'b0);
        compute_drain(1'b0, 20, 30, 32'h300);
        start_pass(1'b1, 1'b0, 1'b1);
        load_pass(0, 1'b0, 1'b0, 1'b1);
        compute_drain(1'b0, 5, -1, 32'h400);
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_drain_pass0();
        test_toggle_spurious();
        test_two_pass_mode1();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/mlp_pass_sequencer.md
Name: mlp_pass_sequencer

Overview:
- Top-level controller for the int8 MLP accelerator. Sequences each pass end to end: load, compute, drain.
- Load phase: accepts the host word stream (16 ifmap words, 1024 weight words, 64 bias words) and writes each word into its GLB region.
- Compute phase: pulses the PE array to start, then waits for it to finish.
- Drain phase: streams 64 output words from the output buffer to the host as valid/ofmap.
- A job is two passes (pass 0, pass 1). `done` pulses after pass 1 has fully drained.

Parameters:
- IFMAP_WORDS, 16, packed 4x int8 ifmap words per pass
- WEIGHT_WORDS, 1024, packed 4x int8 weight words per pass
- BIAS_WORDS, 64, 32-bit bias words per pass
- OUT_WORDS, 64, 32-bit ofmap words drained per pass
- ADDR_W, 10, GLB and output-buffer address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = MLP0, 1 = MLP3; sampled at job start
- ready  in  1  host pulse that starts a pass
- i_en  in  1  data_in word valid
- data_in  in  32  host data word
- glb_we  out  1  GLB write strobe
- glb_sel  out  2  target region: 0 = ifmap, 1 = weight, 2 = bias
- glb_addr  out  ADDR_W  word address within the selected region
- glb_wdata  out  32  write data
- pe_start  out  1  one-cycle compute start pulse
- pe_done  in  1  one-cycle compute finished pulse
- ob_rd_en  out  1  output buffer read enable
- ob_addr  out  ADDR_W  output buffer read address
- ob_rdata  in  32  output buffer read data (1-cycle read latency)
- valid  out  1  ofmap word valid
- ofmap  out  32  output word
- mode_q  out  1  latched mode, exported to the datapath
- pass_id  out  1  current pass (0 or 1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE. Reset mid-operation aborts the job immediately, with no partial done.
- States: IDLE, LD_IF, LD_W, LD_B, COMPUTE, DRAIN, PASS_WAIT.
- IDLE:
  - ready=1 at a posedge moves to LD_IF.
  - mode_q <= mode; pass_id <= 0; word counter cleared.
- PASS_WAIT:
  - ready=1 moves to LD_IF with pass_id=1 and the counter cleared.
  - mode_q is not re-sampled.
- ready is ignored in every state other than IDLE and PASS_WAIT.
- Load states (LD_IF, LD_W, LD_B):
  - A word is accepted at each posedge with i_en=1. i_en=0 stalls with no write.
  - One cycle after acceptance: glb_we=1, glb_sel = region, glb_addr = counter value at acceptance, glb_wdata = data_in.
  - Addresses run 0..N-1 within each region.
  - Accepting word N-1 moves to the next state and clears the counter: LD_IF to LD_W, LD_W to LD_B, LD_B to COMPUTE.
  - The first word of the next region may arrive the very next cycle, with no bubble.
- i_en outside the load states is ignored: no write, and counters do not move.
- COMPUTE:
  - pe_start=1 for exactly the first cycle in the state. The final bias write (glb_we) occurs in that same cycle.
  - pe_done=1 moves to DRAIN.
  - pe_done in any other state is ignored.
- DRAIN:
  - ob_rd_en=1 for 64 consecutive cycles with ob_addr 0..63.
  - valid/ofmap follow exactly 2 cycles after the corresponding ob_rd_en: 1 cycle of read latency plus 1 output register.
  - There is no backpressure, so the drain is exactly 64 contiguous valid cycles.
- After the cycle with the last valid:
  - Pass 0: go to PASS_WAIT and set pass_id <= 1.
  - Pass 1: done=1 for one cycle, go to IDLE, pass_id <= 0.
- ready in the same cycle as the last valid is ignored, because the state is still DRAIN.
- Counters are sized to hold WEIGHT_WORDS-1 without overflow. There is no wrap inside a region; transitions occur exactly at N-1.

Test Plan:
- Reset, then mode=0, ready pulse, i_en held high for 1104 cycles:
  - 16 ifmap writes at addresses 0..15 (sel=0), then 1024 weight writes (sel=1), then 64 bias writes (sel=2).
  - Each glb_wdata equals the accepted data_in, one cycle late.
  - pe_start pulses exactly once, in the same cycle as the last bias write.
- i_en toggled 1,0,1,0 during LD_W:
  - glb_addr advances only on accepted words.
  - No writes occur in the i_en=0 cycles.
- pe_done after 50 cycles, ob_rdata = 0x100+addr:
  - valid is high for exactly 64 cycles; ofmap = 0x100..0x13F in order.
  - State ends in PASS_WAIT with pass_id=1 and busy=1.
- Full two-pass job with mode=1:
  - mode_q=1 throughout, even if mode is driven to 0 before the second ready.
  - done pulses once, 1 cycle after the 128th valid.
  - busy=0 afterwards.
- Spurious inputs:
  - ready during LD_W and pe_done during LD_B are ignored.
  - i_en in COMPUTE produces no glb_we.
- rst asserted mid-DRAIN (word 30):
  - Next cycle all outputs are 0 and the state is IDLE, with no done.
  - A following ready starts pass 0 cleanly.
